// File: rtl/pl_reset_requester.sv
`default_nettype none
// ============================================================================
//  Module   : pl_reset_requester
//  Brief    : Issues a timed active-low reset request (aux_reset_in) to a
//             reset core and supervises the core's peripheral_aresetn
//             response: it waits for the reset to assert, then to release,
//             and reports completion or a timeout.
//  Options  : define PL_RESET_REQ_COUNT_EN to add the 8-bit saturating
//             reset_count output (completed sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module pl_reset_requester #(
   parameter int HOLD_CYCLES    = 16,   // 1..65535
   parameter int TIMEOUT_CYCLES = 1024  // 2..65535
) (
   input  logic       slowest_sync_clk,
   input  logic       ext_reset_in,
   input  logic       req,
   input  logic       peripheral_aresetn,
   output logic       aux_reset_in,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
`ifdef PL_RESET_REQ_COUNT_EN
   ,
   output logic [7:0] reset_count
`endif
);

   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_ASSERT    = 3'd1;
   localparam logic [2:0] c_ST_WAIT_LOW  = 3'd2;
   localparam logic [2:0] c_ST_WAIT_HIGH = 3'd3;
   localparam logic [2:0] c_ST_DONE      = 3'd4;

   // Hold counter counts down from HOLD_CYCLES-1 so ASSERT lasts HOLD_CYCLES.
   localparam logic [15:0] c_HOLD_LOAD = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] c_TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [2:0]  state_q, state_d;
   logic [15:0] hold_q,  hold_d;
   logic [15:0] tmo_q,   tmo_d;
   logic        aux_q,   aux_d;
   logic        err_q,   err_d;

   // Timeout fires in the wait cycle whose increment would reach the limit,
   // so exactly TIMEOUT_CYCLES cycles are spent across WAIT_LOW/WAIT_HIGH.
   logic [15:0] w_tmo_inc;
   logic        w_tmo_expired;
   assign w_tmo_inc     = tmo_q + 16'd1;
   assign w_tmo_expired = (w_tmo_inc == c_TMO_LIMIT);

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge slowest_sync_clk) begin
      if (!ext_reset_in) begin
         state_q <= c_ST_IDLE;
         hold_q  <= 16'd0;
         tmo_q   <= 16'd0;
         aux_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         tmo_q   <= tmo_d;
         aux_q   <= aux_d;
         err_q   <= err_d;
      end
   end

   // Next-state and next-register-value logic
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmo_d   = tmo_q;
      aux_d   = aux_q;
      err_d   = err_q;
      case (state_q)
         c_ST_IDLE: begin
            if (req) begin
               state_d = c_ST_ASSERT;
               hold_d  = c_HOLD_LOAD;
               aux_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         c_ST_ASSERT: begin
            if (hold_q == 16'd0) begin
               state_d = c_ST_WAIT_LOW;
               aux_d   = 1'b1;
               tmo_d   = 16'd0;
            end else begin
               hold_d = hold_q - 16'd1;
            end
         end
         c_ST_WAIT_LOW: begin
            if (w_tmo_expired) begin
               state_d = c_ST_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = w_tmo_inc;
               if (!peripheral_aresetn) begin
                  state_d = c_ST_WAIT_HIGH;
               end
            end
         end
         c_ST_WAIT_HIGH: begin
            if (w_tmo_expired) begin
               state_d = c_ST_IDLE;
               err_d   = 1'b1;
            end else begin
               tmo_d = w_tmo_inc;
               if (peripheral_aresetn) begin
                  state_d = c_ST_DONE;
               end
            end
         end
         c_ST_DONE: begin
            state_d = c_ST_IDLE;
         end
         default: begin
            state_d = c_ST_IDLE;
            aux_d   = 1'b1;
         end
      endcase
   end

   // Outputs decoded from the registered state; aux comes straight off a flop
   always_comb begin
      aux_reset_in = aux_q;
      timeout_err  = err_q;
      busy         = (state_q != c_ST_IDLE);
      done         = (state_q == c_ST_DONE);
   end

`ifdef PL_RESET_REQ_COUNT_EN
   logic [7:0] count_q;

   // Saturating count of completed sequences, bumped on each DONE cycle
   always_ff @(posedge slowest_sync_clk) begin
      if (!ext_reset_in) begin
         count_q <= 8'd0;
      end else if ((state_q == c_ST_DONE) && (count_q != 8'hFF)) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign reset_count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pl_reset_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pl_reset_requester
//  Brief    : Self-checking bench for pl_reset_requester. Two instances with
//             different HOLD/TIMEOUT settings share clock, reset and req;
//             every cycle both are compared to a cycle-age reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pl_reset_requester;

   localparam int HOLD_A = 16;
   localparam int TMO_A  = 64;
   localparam int HOLD_B = 3;
   localparam int TMO_B  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic req   = 1'b0;
   logic pa_a  = 1'b1;
   logic pa_b  = 1'b1;
   logic aux_a, busy_a, done_a, err_a;
   logic aux_b, busy_b, done_b, err_b;
`ifdef PL_RESET_REQ_COUNT_EN
   logic [7:0] cnt_a, cnt_b;
`endif

   pl_reset_requester #(.HOLD_CYCLES(HOLD_A), .TIMEOUT_CYCLES(TMO_A)) u_dut_a (
      .slowest_sync_clk   (clk),
      .ext_reset_in       (rst_n),
      .req                (req),
      .peripheral_aresetn (pa_a),
      .aux_reset_in       (aux_a),
      .busy               (busy_a),
      .done               (done_a),
      .timeout_err        (err_a)
`ifdef PL_RESET_REQ_COUNT_EN
      ,
      .reset_count        (cnt_a)
`endif
   );

   pl_reset_requester #(.HOLD_CYCLES(HOLD_B), .TIMEOUT_CYCLES(TMO_B)) u_dut_b (
      .slowest_sync_clk   (clk),
      .ext_reset_in       (rst_n),
      .req                (req),
      .peripheral_aresetn (pa_b),
      .aux_reset_in       (aux_b),
      .busy               (busy_b),
      .done               (done_b),
      .timeout_err        (err_b)
`ifdef PL_RESET_REQ_COUNT_EN
      ,
      .reset_count        (cnt_b)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a sequence is described by its age (cycles since
   // acceptance). Ages below HOLD are the hold phase; beyond that, the wait
   // index (age-HOLD) bounds the response time.
   int m_hold[2];
   int m_tmo[2];
   bit m_act[2];
   int m_age[2];
   bit m_low[2];
   bit m_done[2];
   bit m_err[2];
   int m_cnt[2];

   task automatic model_edge(input int d, input bit r, input bit q, input bit pa);
      if (!r) begin
         m_act[d] = 0; m_done[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
         m_age[d] = 0; m_low[d] = 0;
      end else if (m_done[d]) begin
         m_done[d] = 0;
         if (m_cnt[d] < 255) m_cnt[d]++;
      end else if (!m_act[d]) begin
         if (q) begin
            m_act[d] = 1; m_age[d] = 0; m_low[d] = 0; m_err[d] = 0;
         end
      end else if (m_age[d] < m_hold[d]) begin
         m_age[d]++;
      end else if (m_age[d] - m_hold[d] == m_tmo[d] - 1) begin
         m_act[d] = 0; m_err[d] = 1;
      end else if (!m_low[d] && !pa) begin
         m_low[d] = 1; m_age[d]++;
      end else if (m_low[d] && pa) begin
         m_act[d] = 0; m_done[d] = 1;
      end else begin
         m_age[d]++;
      end
   endtask

   task automatic cmp_dut(input int d, input logic aux, input logic bsy,
                          input logic dn, input logic er);
      string p;
      p = (d == 0) ? "A" : "B";
      chk({p, " aux_reset_in"}, aux, (m_act[d] && m_age[d] < m_hold[d]) ? 0 : 1);
      chk({p, " busy"}, bsy, (m_act[d] || m_done[d]) ? 1 : 0);
      chk({p, " done"}, dn, m_done[d] ? 1 : 0);
      chk({p, " timeout_err"}, er, m_err[d] ? 1 : 0);
   endtask

   // Drive inputs at the falling edge, clock once, check after the next fall
   task automatic step(input bit r, input bit q, input bit p0, input bit p1);
      rst_n = r; req = q; pa_a = p0; pa_b = p1;
      @(posedge clk);
      model_edge(0, r, q, p0);
      model_edge(1, r, q, p1);
      @(negedge clk);
      cmp_dut(0, aux_a, busy_a, done_a, err_a);
      cmp_dut(1, aux_b, busy_b, done_b, err_b);
`ifdef PL_RESET_REQ_COUNT_EN
      chk("A reset_count", cnt_a, m_cnt[0]);
      chk("B reset_count", cnt_b, m_cnt[1]);
`endif
   endtask

   // Reactive reset core for instance A: pulls peripheral reset low 2 cycles
   // after aux falls, releases it 10 cycles after aux rises.
   bit pa_drv = 1;
   int since_fall = 0;
   int since_rise = 0;
   task automatic periph_a_obs();
      if (!aux_a) begin
         since_fall++;
         since_rise = 0;
         if (since_fall == 2) pa_drv = 0;
      end else begin
         since_fall = 0;
         if (!pa_drv) begin
            since_rise++;
            if (since_rise == 10) pa_drv = 1;
         end
      end
   endtask

   // One request on instance B; pa_b is low for steps lo_at..hi_at-1
   task automatic b_seq(input int lo_at, input int hi_at, output int n_low,
                        output int n_wait, output int n_done, output int fin_err);
      n_low = 0; n_wait = 0; n_done = 0;
      for (int k = 0; k < 14; k++) begin
         step(1, k == 0, 1, (k >= lo_at && k < hi_at) ? 1'b0 : 1'b1);
         if (k == 0) chk("B err clear on accept", err_b, 0);
         if (!aux_b) n_low++;
         if (busy_b && aux_b && !done_b) n_wait++;
         if (done_b) n_done++;
      end
      fin_err = err_b;
   endtask

   typedef struct packed {
      logic r, q, pa;
      logic aux, busy, done, err;
   } vec_t;

   vec_t tv[11];

   initial begin
      int nl, nw, nd, fe, dev, starts, dones, gap;
      bit prev_busy, in_gap, ra, rb;

      tv = '{7'b0011000, 7'b0111000, 7'b1110100, 7'b1010100, 7'b1000100,
             7'b1001100, 7'b1001100, 7'b1011110, 7'b1111000, 7'b1110100,
             7'b0011000};
      m_hold[0] = HOLD_A; m_tmo[0] = TMO_A;
      m_hold[1] = HOLD_B; m_tmo[1] = TMO_B;
      @(negedge clk);

      // Table-driven walk through one complete sequence on instance B
      for (int i = 0; i < 11; i++) begin
         step(tv[i].r, tv[i].q, 1, tv[i].pa);
         chk($sformatf("tbl[%0d] aux", i), aux_b, tv[i].aux);
         chk($sformatf("tbl[%0d] busy", i), busy_b, tv[i].busy);
         chk($sformatf("tbl[%0d] done", i), done_b, tv[i].done);
         chk($sformatf("tbl[%0d] err", i), err_b, tv[i].err);
      end

      // Idle: reset 5 cycles, then 20 quiet cycles
      dev = 0;
      for (int i = 0; i < 25; i++) begin
         step(i >= 5, 0, 1, 1);
         if (!aux_a || busy_a || done_a || err_a) dev++;
         if (!aux_b || busy_b || done_b || err_b) dev++;
      end
      chk("idle deviations", dev, 0);

      // Normal sequence on A with the reactive core
      nl = 0; nd = 0; pa_drv = 1; since_fall = 0; since_rise = 0;
      for (int i = 0; i < 60; i++) begin
         step(1, i == 0, pa_drv, 1);
         periph_a_obs();
         if (!aux_a) nl++;
         if (done_a) nd++;
      end
      chk("A aux low cycles", nl, HOLD_A);
      chk("A done pulses", nd, 1);
      chk("A no timeout", err_a, 0);
`ifdef PL_RESET_REQ_COUNT_EN
      chk("A count after one", cnt_a, 1);
`endif

      // Busy rejection: req high 40 cycles, then low
      step(0, 0, 1, 1);
      step(1, 0, 1, 1);
      pa_drv = 1; since_fall = 0; since_rise = 0;
      starts = 0; dones = 0; gap = 0; prev_busy = 0; in_gap = 0;
      for (int i = 0; i < 90; i++) begin
         step(1, i < 40, pa_drv, 1);
         periph_a_obs();
         if (busy_a && !prev_busy) starts++;
         if (done_a) dones++;
         if (dones == 1 && starts == 1 && !busy_a) gap++;
         prev_busy = busy_a;
      end
      chk("A sequences started", starts, 2);
      chk("A done pulses busy", dones, 2);
      chk("A idle gap cycles", gap, 1);

      // Mid-sequence reset during the fifth hold cycle
      step(1, 1, 1, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1);
      chk("A aux low before abort", aux_a, 0);
      step(0, 0, 1, 1);
      chk("A abort aux", aux_a, 1);
      chk("A abort busy", busy_a, 0);
      chk("A abort err", err_a, 0);
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 1, 1);
         if (done_a || err_a || busy_a) nd++;
      end
      chk("A post-abort activity", nd, 0);

      // Timeout on B with peripheral reset never asserting
      b_seq(99, 99, nl, nw, nd, fe);
      chk("B timeout aux low", nl, HOLD_B);
      chk("B timeout wait cycles", nw, TMO_B);
      chk("B timeout done", nd, 0);
      chk("B timeout err", fe, 1);

      // Progress on the last wait cycle loses to the timeout
      b_seq(4, 11, nl, nw, nd, fe);
      chk("B late release done", nd, 0);
      chk("B late release err", fe, 1);
      // One cycle earlier still completes
      b_seq(4, 10, nl, nw, nd, fe);
      chk("B in-time release done", nd, 1);
      chk("B in-time release err", fe, 0);

      // Randomized traffic against the model
      ra = 1; rb = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) ra = ~ra;
         if ($urandom_range(0, 5) == 0) rb = ~rb;
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, ra, rb);
      end

`ifdef PL_RESET_REQ_COUNT_EN
      // Saturation of the completion count
      step(0, 0, 1, 1);
      for (int i = 0; i < 260; i++) b_seq(4, 6, nl, nw, nd, fe);
      chk("B count saturated", cnt_b, 255);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
